// File: rtl/btb_next_pc_if.sv
// Fetch-side bus of the BTB next-PC generator.
// Carries the EX-stage resolution/redirect inputs, the direction counter
// from the 2-level predictor, and the fetch addresses/prediction returned.
// The address width comes from the ADDR_WIDTH macro (32 when not supplied).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

interface btb_next_pc_if;
  logic                   fetch_stall;
  logic                   redirect_ex;
  logic [`ADDR_WIDTH-1:0] redirect_pc_ex;
  logic                   branch_ex;
  logic                   branch_taken_ex;
  logic [`ADDR_WIDTH-1:0] branch_pc_ex;
  logic [`ADDR_WIDTH-1:0] branch_target_ex;
  logic [1:0]             predictor;
  logic [`ADDR_WIDTH-1:0] next_pc;
  logic [`ADDR_WIDTH-1:0] fetch_pc;
  logic                   pred_taken;
  logic [`ADDR_WIDTH-1:0] pred_target;

  // Pipeline side: drives resolution/stall/counter, consumes fetch addresses.
  modport master (
    output fetch_stall, redirect_ex, redirect_pc_ex,
    output branch_ex, branch_taken_ex, branch_pc_ex, branch_target_ex,
    output predictor,
    input  next_pc, fetch_pc, pred_taken, pred_target
  );

  // Next-PC generator side.
  modport slave (
    input  fetch_stall, redirect_ex, redirect_pc_ex,
    input  branch_ex, branch_taken_ex, branch_pc_ex, branch_target_ex,
    input  predictor,
    output next_pc, fetch_pc, pred_taken, pred_target
  );
endinterface

// File: rtl/btb_next_pc.sv
// Direct-mapped branch target buffer with next fetch address selection.
// fetch_pc is the registered fetch address; next_pc is chosen combinationally
// from redirect, stall, BTB prediction or sequential +4. The direction bit
// is the predictor counter sampled when the address was next_pc.
// Optional macro BTB_WR_BYPASS_EN: a lookup matching a same-cycle BTB write
// (index and tag) returns the write data instead of the old entry.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module btb_next_pc #(
  parameter int                     BTB_ENTRY_NUM = 64,
  parameter logic [`ADDR_WIDTH-1:0] RESET_PC      = 32'h0000_0000
) (
  input logic          cpu_clk,
  input logic          cpu_rst,
  btb_next_pc_if.slave bus
);
  localparam int AW    = `ADDR_WIDTH;
  localparam int IDX_W = $clog2(BTB_ENTRY_NUM);
  localparam int TAG_W = AW - IDX_W - 2;
  localparam logic [AW-1:0] PC_STEP = AW'(4);

  // Valid bits need reset; tag/target storage does not and stays a plain array.
  logic [BTB_ENTRY_NUM-1:0] valid_q;
  logic [TAG_W-1:0]         tag_mem [BTB_ENTRY_NUM];
  logic [AW-1:0]            tgt_mem [BTB_ENTRY_NUM];

  logic [AW-1:0]    fetch_pc_q;
  logic [AW-1:0]    fetch_pc_d;
  logic             pred_dir_q;
  logic             pred_dir_d;

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             wr_en;
  logic             btb_hit;
  logic [AW-1:0]    btb_target;
  logic             pred_taken;
  logic             pred_lsb_unused;

  assign f_idx = fetch_pc_q[IDX_W+1:2];
  assign f_tag = fetch_pc_q[AW-1:IDX_W+2];
  assign w_idx = bus.branch_pc_ex[IDX_W+1:2];
  assign w_tag = bus.branch_pc_ex[AW-1:IDX_W+2];
  assign wr_en = bus.branch_ex & bus.branch_taken_ex;

  // Only the taken bit of the 2-bit counter steers fetch.
  assign pred_lsb_unused = bus.predictor[0];

  // BTB lookup for the current fetch address.
  always_comb begin
    btb_hit    = valid_q[f_idx] && (tag_mem[f_idx] == f_tag);
    btb_target = tgt_mem[f_idx];
`ifdef BTB_WR_BYPASS_EN
    if (wr_en && (w_idx == f_idx) && (w_tag == f_tag)) begin
      btb_hit    = 1'b1;
      btb_target = bus.branch_target_ex;
    end
`endif
  end

  assign pred_taken = btb_hit & pred_dir_q;

  // Next fetch address: redirect beats stall beats prediction beats +4.
  always_comb begin
    fetch_pc_d = fetch_pc_q + PC_STEP;
    if (bus.redirect_ex) begin
      fetch_pc_d = bus.redirect_pc_ex;
    end else if (bus.fetch_stall) begin
      fetch_pc_d = fetch_pc_q;
    end else if (pred_taken) begin
      fetch_pc_d = btb_target;
    end
    pred_dir_d = bus.predictor[1];
  end

  // Fetch address, direction bit and valid bits; cleared by async reset.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      fetch_pc_q <= RESET_PC;
      pred_dir_q <= 1'b0;
      valid_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pred_dir_q <= pred_dir_d;
      if (wr_en) begin
        valid_q[w_idx] <= 1'b1;
      end
    end
  end

  // Tag/target storage: unconditional overwrite on a taken resolved branch.
  always_ff @(posedge cpu_clk) begin
    if (wr_en) begin
      tag_mem[w_idx] <= w_tag;
      tgt_mem[w_idx] <= bus.branch_target_ex;
    end
  end

  assign bus.next_pc     = fetch_pc_d;
  assign bus.fetch_pc    = fetch_pc_q;
  assign bus.pred_taken  = pred_taken;
  assign bus.pred_target = btb_target;
endmodule

// File: tb/tb_btb_next_pc.sv
// Directed bench for btb_next_pc (RESET_PC = 0x100, 64 entries).
// Each table row is applied for one cycle: inputs are set just after a
// rising edge, outputs are compared mid-cycle, then the clock advances.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_btb_next_pc;
  typedef struct {
    logic        rd;
    logic        st;
    logic        br;
    logic        tk;
    logic [31:0] rpc;
    logic [31:0] bpc;
    logic [31:0] btgt;
    logic [1:0]  pred;
    logic [31:0] e_fetch;
    logic        e_pt;
    logic [31:0] e_tgt;
    logic [31:0] e_next;
  } vec_t;

  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b1;
  int   errors  = 0;
  int   checks  = 0;

  btb_next_pc_if bus();

  btb_next_pc #(
    .BTB_ENTRY_NUM(64),
    .RESET_PC     (32'h0000_0100)
  ) dut (
    .cpu_clk(cpu_clk),
    .cpu_rst(cpu_rst),
    .bus    (bus)
  );

  always #5 cpu_clk = ~cpu_clk;

  function automatic vec_t mk(logic rd, logic st, logic br, logic tk,
                              logic [31:0] rpc, logic [31:0] bpc, logic [31:0] btgt,
                              logic [1:0] pred, logic [31:0] e_fetch, logic e_pt,
                              logic [31:0] e_tgt, logic [31:0] e_next);
    vec_t v;
    v.rd = rd; v.st = st; v.br = br; v.tk = tk;
    v.rpc = rpc; v.bpc = bpc; v.btgt = btgt; v.pred = pred;
    v.e_fetch = e_fetch; v.e_pt = e_pt; v.e_tgt = e_tgt; v.e_next = e_next;
    return v;
  endfunction

  task automatic check(input string name, input int id, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, id, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.redirect_ex      = v.rd;
    bus.fetch_stall      = v.st;
    bus.branch_ex        = v.br;
    bus.branch_taken_ex  = v.tk;
    bus.redirect_pc_ex   = v.rpc;
    bus.branch_pc_ex     = v.bpc;
    bus.branch_target_ex = v.btgt;
    bus.predictor        = v.pred;
  endtask

  // One cycle: drive, compare mid-cycle, advance to just after the next edge.
  task automatic apply(input vec_t v, input int id);
    drive(v);
    #1;
    check("fetch_pc", id, bus.fetch_pc, v.e_fetch);
    check("pred_taken", id, {31'b0, bus.pred_taken}, {31'b0, v.e_pt});
    if (v.e_pt) check("pred_target", id, bus.pred_target, v.e_tgt);
    check("next_pc", id, bus.next_pc, v.e_next);
    $display("step %0d: fetch_pc=%h pred_taken=%0b next_pc=%h", id, bus.fetch_pc,
             bus.pred_taken, bus.next_pc);
    @(posedge cpu_clk);
    #1;
  endtask

  vec_t tbl[22];
  vec_t seq[4];
  vec_t idle;

  initial begin
    idle = mk(0,0,0,0, 0,0,0, 2'b00, 0,0,0,0);
    // Free run, BTB fill, predicted taken/not taken, stall/redirect, wrap, alias.
    tbl[0]  = mk(0,0,0,0, 32'h0,        32'h0,   32'h0,   2'b00, 32'h100,      0, 0,       32'h104);
    tbl[1]  = mk(0,0,0,0, 32'h0,        32'h0,   32'h0,   2'b00, 32'h104,      0, 0,       32'h108);
    tbl[2]  = mk(0,0,1,1, 32'h0,        32'h110, 32'h200, 2'b00, 32'h108,      0, 0,       32'h10C);
    tbl[3]  = mk(0,0,0,0, 32'h0,        32'h0,   32'h0,   2'b11, 32'h10C,      0, 0,       32'h110);
    tbl[4]  = mk(0,0,0,0, 32'h0,        32'h0,   32'h0,   2'b00, 32'h110,      1, 32'h200, 32'h200);
    tbl[5]  = mk(1,0,1,1, 32'h10C,      32'h300, 32'h380, 2'b00, 32'h200,      0, 0,       32'h10C);
    tbl[6]  = mk(0,0,0,0, 32'h0,        32'h0,   32'h0,   2'b01, 32'h10C,      0, 0,       32'h110);
    tbl[7]  = mk(0,0,0,0, 32'h0,        32'h0,   32'h0,   2'b00, 32'h110,      0, 0,       32'h114);
    tbl[8]  = mk(1,1,0,0, 32'h400,      32'h0,   32'h0,   2'b00, 32'h114,      0, 0,       32'h400);
    tbl[9]  = mk(0,1,0,0, 32'h0,        32'h0,   32'h0,   2'b00, 32'h400,      0, 0,       32'h400);
    tbl[10] = mk(0,1,0,0, 32'h0,        32'h0,   32'h0,   2'b00, 32'h400,      0, 0,       32'h400);
    tbl[11] = mk(0,1,0,0, 32'h0,        32'h0,   32'h0,   2'b00, 32'h400,      0, 0,       32'h400);
    tbl[12] = mk(1,0,0,0, 32'hFFFFFFFC, 32'h0,   32'h0,   2'b00, 32'h400,      0, 0,       32'hFFFFFFFC);
    tbl[13] = mk(0,0,0,0, 32'h0,        32'h0,   32'h0,   2'b00, 32'hFFFFFFFC, 0, 0,       32'h0);
    tbl[14] = mk(1,0,0,0, 32'h20C,      32'h0,   32'h0,   2'b11, 32'h0,        0, 0,       32'h20C);
    tbl[15] = mk(0,0,0,0, 32'h0,        32'h0,   32'h0,   2'b11, 32'h20C,      0, 0,       32'h210);
    tbl[16] = mk(0,0,1,0, 32'h0,        32'h210, 32'h500, 2'b00, 32'h210,      0, 0,       32'h214);
    tbl[17] = mk(1,0,0,0, 32'h110,      32'h0,   32'h0,   2'b11, 32'h214,      0, 0,       32'h110);
    tbl[18] = mk(0,0,0,0, 32'h0,        32'h0,   32'h0,   2'b00, 32'h110,      1, 32'h200, 32'h200);
    tbl[19] = mk(1,0,0,0, 32'h300,      32'h0,   32'h0,   2'b11, 32'h200,      0, 0,       32'h300);
    tbl[20] = mk(0,0,0,0, 32'h0,        32'h0,   32'h0,   2'b00, 32'h300,      1, 32'h380, 32'h380);
    tbl[21] = mk(0,0,0,0, 32'h0,        32'h0,   32'h0,   2'b00, 32'h380,      0, 0,       32'h384);

    // After a mid-stall reset: same-cycle write/lookup at 0x110, then stalled re-lookup.
    seq[0] = mk(0,0,0,0, 32'h0,   32'h0,   32'h0,   2'b00, 32'h100, 0, 0,       32'h104);
    seq[1] = mk(1,0,0,0, 32'h110, 32'h0,   32'h0,   2'b11, 32'h104, 0, 0,       32'h110);
`ifdef BTB_WR_BYPASS_EN
    seq[2] = mk(0,1,1,1, 32'h0,   32'h110, 32'h300, 2'b11, 32'h110, 1, 32'h300, 32'h110);
`else
    seq[2] = mk(0,1,1,1, 32'h0,   32'h110, 32'h300, 2'b11, 32'h110, 0, 0,       32'h110);
`endif
    seq[3] = mk(0,1,0,0, 32'h0,   32'h0,   32'h0,   2'b11, 32'h110, 1, 32'h300, 32'h110);

    // Reset state with idle inputs.
    drive(idle);
    repeat (2) @(posedge cpu_clk);
    #1;
    check("rst_fetch_pc", -1, bus.fetch_pc, 32'h100);
    check("rst_pred_taken", -1, {31'b0, bus.pred_taken}, 32'h0);
    check("rst_next_pc", -1, bus.next_pc, 32'h104);
    $display("reset: fetch_pc=%h pred_taken=%0b next_pc=%h", bus.fetch_pc, bus.pred_taken,
             bus.next_pc);
    cpu_rst = 1'b0;

    for (int i = 0; i < 22; i++) apply(tbl[i], i);

    // Asynchronous reset mid-cycle while stall and redirect are pending.
    bus.fetch_stall    = 1'b1;
    bus.redirect_ex    = 1'b1;
    bus.redirect_pc_ex = 32'h500;
    #2;
    cpu_rst = 1'b1;
    #1;
    check("arst_fetch_pc", 100, bus.fetch_pc, 32'h100);
    check("arst_pred_taken", 100, {31'b0, bus.pred_taken}, 32'h0);
    check("arst_next_redirect", 100, bus.next_pc, 32'h500);
    bus.redirect_ex = 1'b0;
    #1;
    check("arst_next_stall", 101, bus.next_pc, 32'h100);
    bus.fetch_stall = 1'b0;
    #1;
    check("arst_next_free", 102, bus.next_pc, 32'h104);
    $display("async reset: fetch_pc=%h next_pc=%h", bus.fetch_pc, bus.next_pc);
    @(posedge cpu_clk);
    #1;
    check("arst_hold_fetch_pc", 103, bus.fetch_pc, 32'h100);
    cpu_rst = 1'b0;

    for (int i = 0; i < 4; i++) apply(seq[i], 200 + i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/btb_next_pc.md
BTB_NEXT_PC -- requirements
Module: btb_next_pc

Interface
REQ-001 Parameter: BTB_ENTRY_NUM, default 64, number of direct-mapped BTB entries (power of 2, 4..256).
REQ-002 Parameter: RESET_PC, default 32'h0000_0000, fetch address loaded on reset.
REQ-003 Derived: IDX_W = $clog2(BTB_ENTRY_NUM); TAG_W = `ADDR_WIDTH - IDX_W - 2.
REQ-004 cpu_clk  in  1  sole clock, rising edge.
REQ-005 cpu_rst  in  1  asynchronous, active-high reset.
REQ-006 fetch_stall  in  1  fetch cannot accept a new address this cycle.
REQ-007 redirect_ex  in  1  EX detected a misprediction; fetch restarts at redirect_pc_ex.
REQ-008 redirect_pc_ex  in  `ADDR_WIDTH  correct restart address.
REQ-009 branch_ex  in  1  resolved branch in EX this cycle.
REQ-010 branch_taken_ex  in  1  resolved direction.
REQ-011 branch_pc_ex  in  `ADDR_WIDTH  address of the resolved branch.
REQ-012 branch_target_ex  in  `ADDR_WIDTH  resolved taken target.
REQ-013 predictor  in  2  2-bit direction counter for next_pc from the 2-level predictor; bit[1] = taken.
REQ-014 next_pc  out  `ADDR_WIDTH  combinational address of the next fetch; drives the predictor read index.
REQ-015 fetch_pc  out  `ADDR_WIDTH  registered current fetch address.
REQ-016 pred_taken  out  1  fetch_pc predicted taken (BTB hit AND registered direction).
REQ-017 pred_target  out  `ADDR_WIDTH  BTB target for fetch_pc; valid when pred_taken=1.

Function
REQ-018 BTB entry = {valid, tag[TAG_W], target[`ADDR_WIDTH]}; index = pc[IDX_W+1:2], tag = pc[`ADDR_WIDTH-1:IDX_W+2].
REQ-019 Lookup: btb_hit = valid[idx(fetch_pc)] AND tag match with fetch_pc.
REQ-020 pred_taken = btb_hit AND pred_dir_q; pred_target = target[idx(fetch_pc)].
REQ-021 next_pc priority: redirect_ex -> redirect_pc_ex; else fetch_stall -> fetch_pc; else pred_taken -> pred_target; else fetch_pc + 4 (modulo 2^`ADDR_WIDTH, wraps 32'hFFFF_FFFC -> 0).
REQ-022 Every rising edge: fetch_pc <= next_pc; pred_dir_q <= predictor[1]; so direction used for an address is the counter read when it was next_pc (one-cycle registered, no combinational loop).
REQ-023 During fetch_stall (no redirect) fetch_pc holds, and pred_dir_q reloads with predictor read at the same address, i.e. stays consistent.
REQ-024 redirect_ex overrides fetch_stall in the same cycle.
REQ-025 BTB write: branch_ex AND branch_taken_ex -> entry idx(branch_pc_ex) <= {1, tag(branch_pc_ex), branch_target_ex}, unconditional overwrite (no replacement policy).
REQ-026 Not-taken resolved branch: BTB unchanged (direction learning belongs to the predictor).
REQ-027 Write and lookup to same index in same cycle: see Configuration.
REQ-028 redirect_ex and BTB write in same cycle are independent; both take effect.

Reset
REQ-029 cpu_rst asserted -> immediately: fetch_pc = RESET_PC, pred_dir_q = 0, all valid = 0; tags/targets need no reset.
REQ-030 Outputs during reset: fetch_pc = RESET_PC, pred_taken = 0, next_pc = RESET_PC+4 unless redirect_ex/fetch_stall asserted.
REQ-031 Reset mid-stall or mid-redirect discards the pending state; first post-reset edge follows REQ-021.

Configuration
REQ-032 Macro BTB_WR_BYPASS_EN defined: lookup whose index and tag equal a same-cycle BTB write returns the write data (hit=1, target=branch_target_ex).
REQ-033 Macro undefined: lookup sees pre-write contents; new entry visible from the following cycle.

Verification
REQ-034 Reset with RESET_PC=32'h100 -> fetch_pc=32'h100, pred_taken=0; three free cycles -> fetch_pc 104, 108, 10C.
REQ-035 Write pc=32'h110 target=32'h200 taken; predictor=2'b11 while next_pc=110 -> at fetch_pc=110 pred_taken=1, next_pc=200, next edge fetch_pc=200.
REQ-036 Same entry, predictor=2'b01 when next_pc=110 -> pred_taken=0, next_pc=114.
REQ-037 fetch_stall=1 and redirect_ex=1, redirect_pc_ex=32'h400 same cycle -> fetch_pc=400 next edge; fetch_stall alone 3 cycles -> fetch_pc constant.
REQ-038 fetch_pc=32'h110 while writing pc=110 target=300: with BTB_WR_BYPASS_EN pred_target=300 same cycle (predictor taken); without, miss that cycle, hit following stalled cycle.
REQ-039 fetch_pc=32'hFFFF_FFFC, no hit -> next fetch_pc=0; aliasing pc=32'h210 (same index, different tag as 110, BTB_ENTRY_NUM=64) -> no hit.
